// File: rtl/wb_stage_p_pkg.sv
// Shared layout helpers for the writeback stage: to_wb bus width, field offsets
// and trace-entry width. Bus layout is {pc, dest, result, gr_we}, MSB first.
`ifndef WB_STAGE_P_PKG_SV
`define WB_STAGE_P_PKG_SV
`define WB_TO_WB_W(pc_w, raddr_w, data_w) ((pc_w) + (raddr_w) + (data_w) + 1)

package wb_stage_p_pkg;

    localparam int GR_WE_OFF  = 0;
    localparam int RESULT_OFF = 1;

    function automatic int to_wb_w(input int pc_w, input int raddr_w, input int data_w);
        return pc_w + raddr_w + data_w + 1;
    endfunction

    function automatic int dest_off(input int data_w);
        return data_w + 1;
    endfunction

    function automatic int pc_off(input int raddr_w, input int data_w);
        return data_w + raddr_w + 1;
    endfunction

    // Trace entries reuse the bus layout; the low bit becomes the effective write flag.
    function automatic int trace_w(input int pc_w, input int raddr_w, input int data_w);
        return to_wb_w(pc_w, raddr_w, data_w);
    endfunction

endpackage
`endif

// File: rtl/wb_trace_fifo.sv
// Synchronous FIFO with registered head output; a push into the slot that becomes
// the head is bypassed so the entry is visible one cycle after the push.
module wb_trace_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     push,
    input  logic [WIDTH-1:0]         din,
    input  logic                     pop,
    output logic [WIDTH-1:0]         dout,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_CNT = DEPTH[AW:0];

    logic [WIDTH-1:0] mem [DEPTH];
    logic [WIDTH-1:0] dout_reg;
    logic [AW-1:0]    wr_ptr_reg;
    logic [AW-1:0]    rd_ptr_reg;
    logic [AW-1:0]    rd_ptr_next;
    logic [AW:0]      count_reg;
    logic             push_ok;
    logic             pop_ok;

    assign full    = (count_reg == FULL_CNT);
    assign empty   = (count_reg == '0);
    assign count   = count_reg;
    assign dout    = dout_reg;
    assign push_ok = push && !full;
    assign pop_ok  = pop && !empty;

    always_comb begin
        rd_ptr_next = rd_ptr_reg;
        if (pop_ok) begin
            rd_ptr_next = rd_ptr_reg + AW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            if (push_ok) begin
                wr_ptr_reg <= wr_ptr_reg + AW'(1);
            end
            rd_ptr_reg <= rd_ptr_next;
            case ({push_ok, pop_ok})
                2'b10:   count_reg <= count_reg + (AW+1)'(1);
                2'b01:   count_reg <= count_reg - (AW+1)'(1);
                default: count_reg <= count_reg;
            endcase
        end
    end

    // Storage and head register carry no reset; contents are meaningless while empty.
    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem[wr_ptr_reg] <= din;
        end
        if (push_ok && (wr_ptr_reg == rd_ptr_next)) begin
            dout_reg <= din;
        end else begin
            dout_reg <= mem[rd_ptr_next];
        end
    end

endmodule

// File: rtl/wb_stage_p.sv
// Writeback stage: retires into the register file, forwards the in-flight result and
// logs every retirement into a trace FIFO. Optional retire counter under WB_PERF_CNT_EN.
module wb_stage_p
    import wb_stage_p_pkg::*;
#(
    parameter int PC_W        = 32,
    parameter int DATA_W      = 32,
    parameter int RADDR_W     = 5,
    parameter int TRACE_DEPTH = 4
) (
    input  logic                                           clk,
    input  logic                                           reset,
    input  logic [`WB_TO_WB_W(PC_W, RADDR_W, DATA_W)-1:0]  to_wb_data,
    input  logic                                           mem_to_wb_valid,
    output logic                                           wb_allow_in,
    output logic                                           rf_we,
    output logic [RADDR_W-1:0]                             rf_waddr,
    output logic [DATA_W-1:0]                              rf_wdata,
    output logic                                           wb_fwd_valid,
    output logic [RADDR_W-1:0]                             wb_fwd_dest,
    output logic [DATA_W-1:0]                              wb_fwd_data,
    output logic                                           debug_wb_valid,
    input  logic                                           debug_wb_ready,
    output logic [31:0]                                    debug_wb_pc,
    output logic [3:0]                                     debug_wb_rf_we,
    output logic [4:0]                                     debug_wb_rf_wnum,
    output logic [31:0]                                    debug_wb_rf_wdata
`ifdef WB_PERF_CNT_EN
    ,output logic [31:0]                                   retire_cnt
`endif
);
    localparam int BUS_W    = to_wb_w(PC_W, RADDR_W, DATA_W);
    localparam int DEST_OFF = dest_off(DATA_W);
    localparam int PC_OFF   = pc_off(RADDR_W, DATA_W);
    localparam int TW       = trace_w(PC_W, RADDR_W, DATA_W);
    localparam int CNT_W    = $clog2(TRACE_DEPTH) + 1;

    logic               wb_valid_reg;
    logic [BUS_W-1:0]   payload_reg;
    logic [PC_W-1:0]    wb_pc;
    logic [RADDR_W-1:0] wb_dest;
    logic [DATA_W-1:0]  wb_result;
    logic               wb_gr_we;
    logic               wb_writes_reg;
    logic               wb_ready_go;
    logic               retire;

    logic               trace_full;
    logic               trace_empty;
    logic [CNT_W-1:0]   trace_count;
    logic               trace_pop;
    logic [TW-1:0]      trace_din;
    logic [TW-1:0]      trace_dout;
    logic [PC_W-1:0]    head_pc;
    logic [RADDR_W-1:0] head_dest;
    logic [DATA_W-1:0]  head_data;
    logic               head_we;

    assign wb_pc         = payload_reg[PC_OFF +: PC_W];
    assign wb_dest       = payload_reg[DEST_OFF +: RADDR_W];
    assign wb_result     = payload_reg[RESULT_OFF +: DATA_W];
    assign wb_gr_we      = payload_reg[GR_WE_OFF];
    assign wb_writes_reg = wb_gr_we && (wb_dest != '0);

    // A full trace FIFO is the only reason WB cannot retire.
    assign wb_ready_go = !trace_full;
    assign wb_allow_in = !wb_valid_reg || wb_ready_go;
    assign retire      = wb_valid_reg && wb_ready_go;

    always_ff @(posedge clk) begin
        if (reset) begin
            wb_valid_reg <= 1'b0;
        end else if (wb_allow_in) begin
            wb_valid_reg <= mem_to_wb_valid;
        end
    end

    always_ff @(posedge clk) begin
        if (wb_allow_in && mem_to_wb_valid) begin
            payload_reg <= to_wb_data;
        end
    end

    assign rf_we    = retire && wb_writes_reg;
    assign rf_waddr = wb_dest;
    assign rf_wdata = wb_result;

    assign wb_fwd_valid = wb_valid_reg && wb_writes_reg;
    assign wb_fwd_dest  = wb_dest;
    assign wb_fwd_data  = wb_result;

    assign trace_din = {wb_pc, wb_dest, wb_result, wb_writes_reg};
    assign trace_pop = !trace_empty && debug_wb_ready;

    wb_trace_fifo #(
        .WIDTH (TW),
        .DEPTH (TRACE_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (retire),
        .din   (trace_din),
        .pop   (trace_pop),
        .dout  (trace_dout),
        .full  (trace_full),
        .empty (trace_empty),
        .count (trace_count)
    );

    assign head_pc   = trace_dout[PC_OFF +: PC_W];
    assign head_dest = trace_dout[DEST_OFF +: RADDR_W];
    assign head_data = trace_dout[RESULT_OFF +: DATA_W];
    assign head_we   = trace_dout[GR_WE_OFF];

    assign debug_wb_valid = (trace_count != '0);

    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_strobe
            assign debug_wb_rf_we[gi] = head_we;
        end

        if (PC_W >= 32) begin : g_pc_trunc
            assign debug_wb_pc = head_pc[31:0];
        end else begin : g_pc_ext
            assign debug_wb_pc = {{(32-PC_W){1'b0}}, head_pc};
        end

        if (DATA_W >= 32) begin : g_data_trunc
            assign debug_wb_rf_wdata = head_data[31:0];
        end else begin : g_data_ext
            assign debug_wb_rf_wdata = {{(32-DATA_W){1'b0}}, head_data};
        end

        if (RADDR_W >= 5) begin : g_wnum_trunc
            assign debug_wb_rf_wnum = head_dest[4:0];
        end else begin : g_wnum_ext
            assign debug_wb_rf_wnum = {{(5-RADDR_W){1'b0}}, head_dest};
        end
    endgenerate

`ifdef WB_PERF_CNT_EN
    logic [31:0] retire_cnt_reg;

    always_ff @(posedge clk) begin
        if (reset) begin
            retire_cnt_reg <= '0;
        end else if (retire) begin
            retire_cnt_reg <= retire_cnt_reg + 32'd1;
        end
    end

    assign retire_cnt = retire_cnt_reg;
`endif

endmodule

// File: tb/tb_wb_stage_p.sv
// Bench for wb_stage_p: directed vector table, hand-written multi-cycle sequences and
// a randomized run against a queue-based reference model.
module tb_wb_stage_p;

    logic        clk;
    logic        reset;
    logic [69:0] to_wb_data;
    logic        mem_to_wb_valid;
    logic        wb_allow_in;
    logic        rf_we;
    logic [4:0]  rf_waddr;
    logic [31:0] rf_wdata;
    logic        wb_fwd_valid;
    logic [4:0]  wb_fwd_dest;
    logic [31:0] wb_fwd_data;
    logic        debug_wb_valid;
    logic        debug_wb_ready;
    logic [31:0] debug_wb_pc;
    logic [3:0]  debug_wb_rf_we;
    logic [4:0]  debug_wb_rf_wnum;
    logic [31:0] debug_wb_rf_wdata;
`ifdef WB_PERF_CNT_EN
    logic [31:0] retire_cnt;
`endif

    wb_stage_p dut (
        .clk               (clk),
        .reset             (reset),
        .to_wb_data        (to_wb_data),
        .mem_to_wb_valid   (mem_to_wb_valid),
        .wb_allow_in       (wb_allow_in),
        .rf_we             (rf_we),
        .rf_waddr          (rf_waddr),
        .rf_wdata          (rf_wdata),
        .wb_fwd_valid      (wb_fwd_valid),
        .wb_fwd_dest       (wb_fwd_dest),
        .wb_fwd_data       (wb_fwd_data),
        .debug_wb_valid    (debug_wb_valid),
        .debug_wb_ready    (debug_wb_ready),
        .debug_wb_pc       (debug_wb_pc),
        .debug_wb_rf_we    (debug_wb_rf_we),
        .debug_wb_rf_wnum  (debug_wb_rf_wnum),
        .debug_wb_rf_wdata (debug_wb_rf_wdata)
`ifdef WB_PERF_CNT_EN
        ,.retire_cnt       (retire_cnt)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    logic [69:0] send_q[$];
    logic [31:0] recv_q[$];
    logic [31:0] exp_pc[$];

    typedef struct {
        logic [31:0] pc;
        logic [4:0]  dest;
        logic [31:0] result;
        logic        gr_we;
        logic        exp_rf_we;
        logic        exp_fwd;
        logic [3:0]  exp_strobe;
    } vec_t;

    vec_t vecs[4];

    function automatic logic [69:0] pack(logic [31:0] pc, logic [4:0] d, logic [31:0] r, logic w);
        return {pc, d, r, w};
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, want %0h", name, act, exp);
        end
    endtask

    // One clock: present the head of send_q, log any trace pop, advance to next negedge.
    task automatic step();
        logic acc;
        if (send_q.size() > 0) begin
            mem_to_wb_valid = 1'b1;
            to_wb_data      = send_q[0];
        end else begin
            mem_to_wb_valid = 1'b0;
        end
        #1;
        acc = wb_allow_in && mem_to_wb_valid;
        if (debug_wb_valid && debug_wb_ready) recv_q.push_back(debug_wb_pc);
        @(posedge clk);
        if (acc) void'(send_q.pop_front());
        @(negedge clk);
    endtask

    task automatic do_reset();
        reset           = 1'b1;
        mem_to_wb_valid = 1'b0;
        send_q.delete();
        recv_q.delete();
        exp_pc.delete();
        @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic drain_and_check(input string name, input int n);
        for (int c = 0; c < 60 && recv_q.size() < n; c++) step();
        chk({name, "_count"}, 64'(recv_q.size()), 64'(n));
        for (int i = 0; i < n && i < recv_q.size(); i++) chk({name, "_order"}, recv_q[i], exp_pc[i]);
    endtask

    // Reference model state
    bit          m_wbv;
    logic [69:0] m_slot;
    logic [69:0] m_q[$];

    initial begin
        reset           = 1'b1;
        mem_to_wb_valid = 1'b0;
        to_wb_data      = '0;
        debug_wb_ready  = 1'b1;
        @(negedge clk);
        do_reset();

        chk("rst_dbg_valid", debug_wb_valid, 0);
        chk("rst_allow_in", wb_allow_in, 1);
        chk("rst_rf_we", rf_we, 0);
        chk("rst_fwd_valid", wb_fwd_valid, 0);

        // Isolated transactions: rf write next cycle, trace head one cycle later.
        vecs[0] = '{32'h1c000000, 5'd3,  32'hDEADBEEF, 1'b1, 1'b1, 1'b1, 4'hF};
        vecs[1] = '{32'h1c000004, 5'd0,  32'h00000005, 1'b1, 1'b0, 1'b0, 4'h0};
        vecs[2] = '{32'h1c000008, 5'd7,  32'h12345678, 1'b0, 1'b0, 1'b0, 4'h0};
        vecs[3] = '{32'h1c00000c, 5'd31, 32'hFFFFFFFF, 1'b1, 1'b1, 1'b1, 4'hF};
        debug_wb_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            send_q.push_back(pack(vecs[i].pc, vecs[i].dest, vecs[i].result, vecs[i].gr_we));
            step();
            chk("vec_rf_we", rf_we, vecs[i].exp_rf_we);
            chk("vec_rf_waddr", rf_waddr, vecs[i].dest);
            chk("vec_rf_wdata", rf_wdata, vecs[i].result);
            chk("vec_fwd_valid", wb_fwd_valid, vecs[i].exp_fwd);
            chk("vec_fwd_data", wb_fwd_data, vecs[i].result);
            step();
            chk("vec_rf_we_after", rf_we, 0);
            chk("vec_dbg_valid", debug_wb_valid, 1);
            chk("vec_dbg_pc", debug_wb_pc, vecs[i].pc);
            chk("vec_dbg_wnum", debug_wb_rf_wnum, vecs[i].dest);
            chk("vec_dbg_wdata", debug_wb_rf_wdata, vecs[i].result);
            chk("vec_dbg_strobe", debug_wb_rf_we, vecs[i].exp_strobe);
            step();
            chk("vec_dbg_popped", debug_wb_valid, 0);
            $display("vec %0d pc=%08h dest=%0d result=%08h gr_we=%0b", i,
                     vecs[i].pc, vecs[i].dest, vecs[i].result, vecs[i].gr_we);
        end

        // Backpressure: sink stalled, six back-to-back instructions.
        do_reset();
        debug_wb_ready = 1'b0;
        for (int i = 0; i < 6; i++) begin
            send_q.push_back(pack(32'h1c001000 + 32'(i * 4), 5'(i + 1), 32'h000000A0 + 32'(i), 1'b1));
            exp_pc.push_back(32'h1c001000 + 32'(i * 4));
        end
        repeat (5) step();
        chk("bp_allow_in", wb_allow_in, 0);
        chk("bp_rf_we", rf_we, 0);
        chk("bp_fwd_valid", wb_fwd_valid, 1);
        chk("bp_fwd_dest", wb_fwd_dest, 5);
        chk("bp_head_pc", debug_wb_pc, 32'h1c001000);
        step();
        chk("bp_pending", 64'(send_q.size()), 1);
        chk("bp_allow_in2", wb_allow_in, 0);
        debug_wb_ready = 1'b1;
        drain_and_check("bp", 6);
        $display("backpressure sequence: %0d entries drained", recv_q.size());

        // Steady push+pop at occupancy 2 across several pointer wraps.
        do_reset();
        debug_wb_ready = 1'b0;
        for (int i = 0; i < 14; i++) begin
            send_q.push_back(pack(32'h1c003000 + 32'(i * 4), 5'd2, 32'(i), 1'b1));
            exp_pc.push_back(32'h1c003000 + 32'(i * 4));
        end
        repeat (3) step();
        debug_wb_ready = 1'b1;
        for (int k = 0; k < 10; k++) begin
            chk("pp_count", 64'(dut.u_fifo.count_reg), 2);
            step();
        end
        drain_and_check("pp", 14);
        $display("push/pop sequence: %0d entries drained", recv_q.size());

        // Reset while full and stalled.
        do_reset();
        debug_wb_ready = 1'b0;
        for (int i = 0; i < 6; i++) send_q.push_back(pack(32'h1c004000 + 32'(i * 4), 5'd4, 32'(i), 1'b1));
        repeat (6) step();
        chk("rs_pre_allow", wb_allow_in, 0);
        do_reset();
        chk("rs_dbg_valid", debug_wb_valid, 0);
        chk("rs_allow_in", wb_allow_in, 1);
        chk("rs_rf_we", rf_we, 0);
        debug_wb_ready = 1'b1;
        send_q.push_back(pack(32'h1c002000, 5'd9, 32'hCAFEF00D, 1'b1));
        step();
        chk("rs_new_rf_we", rf_we, 1);
        chk("rs_new_waddr", rf_waddr, 9);
        chk("rs_new_wdata", rf_wdata, 32'hCAFEF00D);
        step();
        chk("rs_new_dbg_valid", debug_wb_valid, 1);
        chk("rs_new_dbg_pc", debug_wb_pc, 32'h1c002000);
        $display("reset-mid-stall sequence done");

`ifdef WB_PERF_CNT_EN
        do_reset();
        chk("perf_rst", retire_cnt, 0);
        debug_wb_ready = 1'b0;
        send_q.push_back(pack(32'h1c005000, 5'd1, 32'h1, 1'b1));
        send_q.push_back(pack(32'h1c005004, 5'd2, 32'h2, 1'b0));
        send_q.push_back(pack(32'h1c005008, 5'd3, 32'h3, 1'b1));
        repeat (4) step();
        chk("perf_cnt3", retire_cnt, 3);
        repeat (2) step();
        chk("perf_cnt3_idle", retire_cnt, 3);
        send_q.push_back(pack(32'h1c00500c, 5'd4, 32'h4, 1'b1));
        step();
        force dut.retire_cnt_reg = 32'hFFFFFFFF;
        #1;
        release dut.retire_cnt_reg;
        step();
        chk("perf_wrap", retire_cnt, 0);
        $display("perf counter sequence done");
`endif

        // Randomized traffic against the queue model.
        do_reset();
        m_wbv = 1'b0;
        m_q.delete();
        for (int cyc = 0; cyc < 400; cyc++) begin
            bit          mv;
            bit          rdy;
            bit          full_m;
            bit          ret_m;
            bit          allow_m;
            logic [69:0] d;
            logic [69:0] h;
            mv  = ($urandom_range(0, 3) != 0);
            rdy = ($urandom_range(0, 2) != 0);
            d   = pack($urandom, 5'($urandom_range(0, 3) == 0 ? 0 : $urandom_range(1, 31)),
                       $urandom, 1'($urandom_range(0, 1)));
            mem_to_wb_valid = mv;
            to_wb_data      = d;
            debug_wb_ready  = rdy;
            #1;
            full_m  = (m_q.size() == 4);
            ret_m   = m_wbv && !full_m;
            allow_m = !m_wbv || !full_m;
            chk("rnd_allow_in", wb_allow_in, allow_m);
            chk("rnd_rf_we", rf_we, ret_m && m_slot[0] && (m_slot[37:33] != 0));
            chk("rnd_fwd_valid", wb_fwd_valid, m_wbv && m_slot[0] && (m_slot[37:33] != 0));
            if (m_wbv) begin
                chk("rnd_rf_waddr", rf_waddr, m_slot[37:33]);
                chk("rnd_rf_wdata", rf_wdata, m_slot[32:1]);
            end
            chk("rnd_dbg_valid", debug_wb_valid, m_q.size() != 0);
            if (m_q.size() != 0) begin
                h = m_q[0];
                chk("rnd_dbg_pc", debug_wb_pc, h[69:38]);
                chk("rnd_dbg_wnum", debug_wb_rf_wnum, h[37:33]);
                chk("rnd_dbg_wdata", debug_wb_rf_wdata, h[32:1]);
                chk("rnd_dbg_strobe", debug_wb_rf_we, {4{h[0]}});
            end
            @(posedge clk);
            if (m_q.size() != 0 && rdy) void'(m_q.pop_front());
            if (ret_m) begin
                h    = m_slot;
                h[0] = m_slot[0] && (m_slot[37:33] != 0);
                m_q.push_back(h);
            end
            if (allow_m) begin
                m_wbv = mv;
                if (mv) m_slot = d;
            end
            @(negedge clk);
        end
        $display("random run: 400 cycles");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

endmodule
